pht_sat_predictor: RTL

- Parametrised pattern history table of ENTRIES = 2**INDEX_BITS saturating counters, each CTR_WIDTH bits wide. Generalises the single 2-bit counter.
- Serves the fetch stage with a registered taken/not-taken prediction per lookup.
- Trained by the branch-resolution stage through one update port.
- Optional gshare indexing through a global history register.

---
 rtl/bp_pkg.sv | 18 +
 rtl/sat_counter_nbit.sv | 31 +++
 rtl/pht_sat_predictor.sv | 105 ++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared types and counter helpers for the branch predictor tables.
package bp_pkg;

  localparam int CTR_WIDTH_DEF  = 2;
  localparam int INDEX_BITS_DEF = 6;

  typedef logic [CTR_WIDTH_DEF-1:0]  ctr_t;
  typedef logic [INDEX_BITS_DEF-1:0] idx_t;

  function automatic int ctr_default(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  function automatic int ctr_max(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/sat_counter_nbit.sv
// One N-bit saturating counter; counts up on in=1, down on in=0 when enabled.
module sat_counter_nbit
  import bp_pkg::*;
#(
  parameter int CTR_WIDTH     = 2,
  parameter int DEFAULT_VALUE = ctr_default(CTR_WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enabled,
  input  logic                 in,
  output logic [CTR_WIDTH-1:0] count
);

  localparam logic [CTR_WIDTH-1:0] MAX  = CTR_WIDTH'(ctr_max(CTR_WIDTH));
  localparam logic [CTR_WIDTH-1:0] INIT = CTR_WIDTH'(DEFAULT_VALUE);
  localparam logic [CTR_WIDTH-1:0] ONE  = CTR_WIDTH'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= INIT;
    end else if (enabled) begin
      if (in && count != MAX) begin
        count <= count + ONE;
      end else if (!in && count != '0) begin
        count <= count - ONE;
      end
    end
  end

endmodule

// File: rtl/pht_sat_predictor.sv
// Pattern history table of saturating counters with registered lookup.
// Define PHT_GSHARE_EN to hash the index with a global history register.
module pht_sat_predictor
  import bp_pkg::*;
#(
  parameter int CTR_WIDTH     = 2,
  parameter int INDEX_BITS    = 6,
  parameter int PC_WIDTH      = 32,
  parameter int DEFAULT_VALUE = ctr_default(CTR_WIDTH),
  parameter int HIST_BITS     = INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pred_valid,
  input  logic [PC_WIDTH-1:0]   pred_pc,
  output logic                  pred_out_valid,
  output logic                  pred_taken,
  output logic [CTR_WIDTH-1:0]  pred_ctr,
  output logic [INDEX_BITS-1:0] pred_index,
  input  logic                  upd_valid,
  input  logic [INDEX_BITS-1:0] upd_index,
  input  logic                  upd_taken
);

  localparam int ENTRIES = 2 ** INDEX_BITS;
  localparam logic [CTR_WIDTH-1:0] MAX = CTR_WIDTH'(ctr_max(CTR_WIDTH));
  localparam logic [CTR_WIDTH-1:0] ONE = CTR_WIDTH'(1);

  logic [CTR_WIDTH-1:0]  ctrs [ENTRIES];
  logic [INDEX_BITS-1:0] pc_idx;
  logic [INDEX_BITS-1:0] idx;
  logic [CTR_WIDTH-1:0]  upd_cur;
  logic [CTR_WIDTH-1:0]  upd_next;
  logic [CTR_WIDTH-1:0]  eff;
  logic                  unused_pc;

  assign pc_idx    = pred_pc[INDEX_BITS+1:2];
  assign unused_pc = ^{pred_pc[PC_WIDTH-1:INDEX_BITS+2], pred_pc[1:0]};

`ifdef PHT_GSHARE_EN
  logic [HIST_BITS-1:0] ghr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr <= '0;
    end else if (upd_valid) begin
      ghr <= {ghr[HIST_BITS-2:0], upd_taken};
    end
  end

  // Lookups hash with the history as it stood before this cycle's update.
  assign idx = pc_idx ^ INDEX_BITS'(ghr);
`else
  assign idx = pc_idx;
`endif

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
    sat_counter_nbit #(
      .CTR_WIDTH    (CTR_WIDTH),
      .DEFAULT_VALUE(DEFAULT_VALUE)
    ) u_ctr (
      .clk    (clk),
      .reset  (reset),
      .enabled(upd_valid && (upd_index == INDEX_BITS'(i))),
      .in     (upd_taken),
      .count  (ctrs[i])
    );
  end

  assign upd_cur = ctrs[upd_index];

  always_comb begin
    upd_next = upd_cur;
    if (upd_taken && upd_cur != MAX) begin
      upd_next = upd_cur + ONE;
    end else if (!upd_taken && upd_cur != '0) begin
      upd_next = upd_cur - ONE;
    end
  end

  // Write-first: a same-cycle update to the looked-up entry is forwarded.
  always_comb begin
    eff = ctrs[idx];
    if (upd_valid && upd_index == idx) begin
      eff = upd_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pred_out_valid <= 1'b0;
      pred_taken     <= 1'b0;
      pred_ctr       <= '0;
      pred_index     <= '0;
    end else begin
      pred_out_valid <= pred_valid;
      if (pred_valid) begin
        pred_taken <= eff[CTR_WIDTH-1];
        pred_ctr   <= eff;
        pred_index <= idx;
      end
    end
  end

endmodule
